// File: rtl/s_term_cfg_pipe.sv
// Configuration-frame pass-through for a fabric tile: retimes FrameData/FrameStrobe
// to the tile above and monitors the strobe protocol on the unretimed inputs.
module s_term_cfg_pipe #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int PipeStages      = 1
) (
    input  logic                       UserCLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic                       err_clr,
    output logic                       UserCLKo,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic [15:0]                frame_cnt,
    output logic [4:0]                 last_frame,
    output logic                       last_parity,
    output logic                       cfg_err
);

    assign UserCLKo = UserCLK;

    // Data and strobe travel through one shared chain so they can never skew.
    if (PipeStages == 0) begin : gNoPipe
        assign FrameData_O   = FrameData;
        assign FrameStrobe_O = FrameStrobe;
    end else begin : gPipe
        logic [FrameBitsPerRow-1:0] dataPipe   [PipeStages];
        logic [MaxFramesPerCol-1:0] strobePipe [PipeStages];

        always_ff @(posedge UserCLK or negedge resetn) begin
            if (!resetn) begin
                for (int i = 0; i < PipeStages; i++) begin
                    dataPipe[i]   <= '0;
                    strobePipe[i] <= '0;
                end
            end else begin
                dataPipe[0]   <= FrameData;
                strobePipe[0] <= FrameStrobe;
                for (int i = 1; i < PipeStages; i++) begin
                    dataPipe[i]   <= dataPipe[i-1];
                    strobePipe[i] <= strobePipe[i-1];
                end
            end
        end

        assign FrameData_O   = dataPipe[PipeStages-1];
        assign FrameStrobe_O = strobePipe[PipeStages-1];
    end

    logic [MaxFramesPerCol-1:0] prevStrobe;
    logic [MaxFramesPerCol-1:0] strobeRise;
    logic                       frameEvent;
    logic [4:0]                 lowestRise;
    logic                       multiHot;
    logic                       longHigh;
    logic [1:0]                 hiCnt [MaxFramesPerCol];

    assign strobeRise = FrameStrobe & ~prevStrobe;
    assign frameEvent = |strobeRise;
    assign multiHot   = |(FrameStrobe & (FrameStrobe - MaxFramesPerCol'(1)));

    always_comb begin
        lowestRise = '0;
        for (int i = MaxFramesPerCol - 1; i >= 0; i--) begin
            if (strobeRise[i]) lowestRise = 5'(i);
        end
    end

    // hiCnt holds the number of previous consecutive high cycles, so a bit that
    // is high now with hiCnt >= 2 is in its third (or later) high cycle.
    always_comb begin
        longHigh = 1'b0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            if (FrameStrobe[i] && hiCnt[i] >= 2'd2) longHigh = 1'b1;
        end
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            prevStrobe <= '0;
            for (int i = 0; i < MaxFramesPerCol; i++) hiCnt[i] <= 2'd0;
        end else begin
            prevStrobe <= FrameStrobe;
            for (int i = 0; i < MaxFramesPerCol; i++) begin
                if (!FrameStrobe[i])        hiCnt[i] <= 2'd0;
                else if (hiCnt[i] != 2'd3)  hiCnt[i] <= hiCnt[i] + 2'd1;
            end
        end
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            frame_cnt   <= '0;
            last_frame  <= '0;
            last_parity <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (frameEvent) begin
                if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
                last_frame  <= lowestRise;
                last_parity <= ^FrameData;
            end
            if (multiHot || longHigh) cfg_err <= 1'b1;
            else if (err_clr)         cfg_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_s_term_cfg_pipe.sv
// Bench for s_term_cfg_pipe: directed vector table, hand sequences and random
// traffic checked against a queue-based reference model.
module tb_s_term_cfg_pipe;

    logic        UserCLK;
    logic        resetn;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        err_clr;

    logic        clko0, clko2, clko3;
    logic [31:0] data0, data2, data3;
    logic [19:0] strb0, strb2, strb3;
    logic [15:0] cnt0, cnt2, cnt3;
    logic [4:0]  last0, last2, last3;
    logic        par0, par2, par3;
    logic        err0, err2, err3;

    s_term_cfg_pipe #(.MaxFramesPerCol(20), .FrameBitsPerRow(32), .PipeStages(0)) u0 (
        .UserCLK(UserCLK), .resetn(resetn), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .err_clr(err_clr), .UserCLKo(clko0), .FrameData_O(data0), .FrameStrobe_O(strb0),
        .frame_cnt(cnt0), .last_frame(last0), .last_parity(par0), .cfg_err(err0));

    s_term_cfg_pipe #(.MaxFramesPerCol(20), .FrameBitsPerRow(32), .PipeStages(2)) u2 (
        .UserCLK(UserCLK), .resetn(resetn), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .err_clr(err_clr), .UserCLKo(clko2), .FrameData_O(data2), .FrameStrobe_O(strb2),
        .frame_cnt(cnt2), .last_frame(last2), .last_parity(par2), .cfg_err(err2));

    s_term_cfg_pipe #(.MaxFramesPerCol(20), .FrameBitsPerRow(32), .PipeStages(3)) u3 (
        .UserCLK(UserCLK), .resetn(resetn), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .err_clr(err_clr), .UserCLKo(clko3), .FrameData_O(data3), .FrameStrobe_O(strb3),
        .frame_cnt(cnt3), .last_frame(last3), .last_parity(par3), .cfg_err(err3));

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    int nPass;
    int nTotal;

    // Reference model state
    int          mCnt;
    int          mLast;
    bit          mPar;
    bit          mErr;
    logic [19:0] mPrev;
    int          runLen [20];
    logic [31:0] histD [$];
    logic [19:0] histS [$];

    typedef struct {
        logic [19:0] strobe;
        logic [31:0] data;
        logic        clr;
        logic [15:0] cnt;
        logic [4:0]  last;
        logic        par;
        logic        err;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic modelReset();
        mCnt = 0; mLast = 0; mPar = 0; mErr = 0; mPrev = '0;
        for (int i = 0; i < 20; i++) runLen[i] = 0;
        histD.delete();
        histS.delete();
    endtask

    task automatic modelEdge();
        logic [19:0] rise;
        bit viol;
        rise = FrameStrobe & ~mPrev;
        viol = ($countones(FrameStrobe) > 1);
        if (rise != 0) begin
            if (mCnt < 65535) mCnt++;
            for (int i = 19; i >= 0; i--) if (rise[i]) mLast = i;
            mPar = ($countones(FrameData) % 2) == 1;
        end
        for (int i = 0; i < 20; i++) begin
            runLen[i] = FrameStrobe[i] ? ((runLen[i] < 3) ? runLen[i] + 1 : 3) : 0;
            if (runLen[i] > 2) viol = 1;
        end
        if (viol) mErr = 1;
        else if (err_clr) mErr = 0;
        mPrev = FrameStrobe;
        histD.push_back(FrameData);
        histS.push_back(FrameStrobe);
        if (histD.size() > 4) begin
            void'(histD.pop_front());
            void'(histS.pop_front());
        end
    endtask

    function automatic logic [31:0] expD(int n);
        if (histD.size() < n) return '0;
        return histD[histD.size() - n];
    endfunction

    function automatic logic [19:0] expS(int n);
        if (histS.size() < n) return '0;
        return histS[histS.size() - n];
    endfunction

    task automatic compareModel();
        check("frame_cnt", 64'(cnt2), 64'(mCnt));
        check("last_frame", 64'(last2), 64'(mLast));
        check("last_parity", 64'(par2), 64'(mPar));
        check("cfg_err", 64'(err2), 64'(mErr));
        check("cfg_err_p3", 64'(err3), 64'(mErr));
        check("data_p2", 64'(data2), 64'(expD(2)));
        check("strobe_p2", 64'(strb2), 64'(expS(2)));
        check("data_p3", 64'(data3), 64'(expD(3)));
        check("strobe_p3", 64'(strb3), 64'(expS(3)));
        check("data_p0", 64'(data0), 64'(FrameData));
        check("strobe_p0", 64'(strb0), 64'(FrameStrobe));
        check("clko", 64'(clko2), 64'(UserCLK));
    endtask

    task automatic step(input bit doCheck);
        @(posedge UserCLK);
        modelEdge();
        #1;
        if (doCheck) compareModel();
    endtask

    task automatic resetSeq();
        @(negedge UserCLK);
        resetn = 1'b0;
        #1;
        modelReset();
        check("rst_cnt", 64'(cnt2), 64'd0);
        check("rst_last", 64'(last2), 64'd0);
        check("rst_par", 64'(par2), 64'd0);
        check("rst_err", 64'(err2), 64'd0);
        check("rst_data_p2", 64'(data2), 64'd0);
        check("rst_data_p3", 64'(data3), 64'd0);
        check("rst_strobe_p3", 64'(strb3), 64'd0);
        @(negedge UserCLK);
        resetn = 1'b1;
    endtask

    task automatic setIn(input logic [19:0] s, input logic [31:0] d, input logic c);
        FrameStrobe = s;
        FrameData   = d;
        err_clr     = c;
    endtask

    initial begin
        nPass = 0;
        nTotal = 0;
        resetn = 1'b0;
        setIn('0, '0, 1'b0);
        modelReset();

        vecs[0]  = '{20'h00008, 32'h1, 1'b0, 16'd1, 5'd3,  1'b1, 1'b0};
        vecs[1]  = '{20'h00000, 32'h3, 1'b0, 16'd1, 5'd3,  1'b1, 1'b0};
        vecs[2]  = '{20'h00080, 32'h7, 1'b0, 16'd2, 5'd7,  1'b1, 1'b0};
        vecs[3]  = '{20'h00000, 32'h0, 1'b0, 16'd2, 5'd7,  1'b1, 1'b0};
        vecs[4]  = '{20'h80000, 32'hF, 1'b0, 16'd3, 5'd19, 1'b0, 1'b0};
        vecs[5]  = '{20'h00000, 32'h1, 1'b0, 16'd3, 5'd19, 1'b0, 1'b0};
        vecs[6]  = '{20'h00006, 32'h0, 1'b0, 16'd4, 5'd1,  1'b0, 1'b1};
        vecs[7]  = '{20'h00000, 32'h1, 1'b0, 16'd4, 5'd1,  1'b0, 1'b1};
        vecs[8]  = '{20'h00000, 32'h0, 1'b1, 16'd4, 5'd1,  1'b0, 1'b0};
        vecs[9]  = '{20'h00006, 32'h1, 1'b1, 16'd5, 5'd1,  1'b1, 1'b1};
        vecs[10] = '{20'h00000, 32'h0, 1'b1, 16'd5, 5'd1,  1'b1, 1'b0};
        vecs[11] = '{20'h00020, 32'h0, 1'b0, 16'd6, 5'd5,  1'b0, 1'b0};
        vecs[12] = '{20'h00020, 32'h1, 1'b0, 16'd6, 5'd5,  1'b0, 1'b0};
        vecs[13] = '{20'h00020, 32'h1, 1'b0, 16'd6, 5'd5,  1'b0, 1'b1};
        vecs[14] = '{20'h00000, 32'h0, 1'b0, 16'd6, 5'd5,  1'b0, 1'b1};
        vecs[15] = '{20'h00000, 32'h0, 1'b1, 16'd6, 5'd5,  1'b0, 1'b0};

        // Single frame through a two-stage pipe
        resetSeq();
        setIn(20'h00001, 32'hA5A5_0001, 1'b0);
        step(1);
        check("p2_lat_edge1", 64'(data2), 64'd0);
        check("p2_cnt", 64'(cnt2), 64'd1);
        check("p2_last", 64'(last2), 64'd0);
        check("p2_par", 64'(par2), 64'(^32'hA5A5_0001));
        setIn('0, '0, 1'b0);
        step(1);
        check("p2_lat_data", 64'(data2), 64'hA5A5_0001);
        check("p2_lat_strobe", 64'(strb2), 64'h1);
        step(1);
        check("p2_lat_edge3", 64'(data2), 64'd0);

        // Directed vector table
        resetSeq();
        for (int v = 0; v < 16; v++) begin
            setIn(vecs[v].strobe, vecs[v].data, vecs[v].clr);
            step(1);
            check($sformatf("vec%0d_cnt", v), 64'(cnt2), 64'(vecs[v].cnt));
            check($sformatf("vec%0d_last", v), 64'(last2), 64'(vecs[v].last));
            check($sformatf("vec%0d_par", v), 64'(par2), 64'(vecs[v].par));
            check($sformatf("vec%0d_err", v), 64'(err2), 64'(vecs[v].err));
        end

        // Strobe already high when reset releases counts as a rise
        setIn(20'h00004, 32'h0, 1'b0);
        resetSeq();
        step(1);
        check("rel_rise_cnt", 64'(cnt2), 64'd1);
        check("rel_rise_last", 64'(last2), 64'd2);
        setIn('0, '0, 1'b0);
        step(1);

        // Reset in the middle of a three-stage pipe discards the frame
        resetSeq();
        setIn(20'h00010, 32'hDEAD_BEEF, 1'b0);
        step(1);
        setIn('0, '0, 1'b0);
        step(1);
        resetSeq();
        for (int k = 0; k < 6; k++) begin
            step(1);
            check($sformatf("flush%0d_data", k), 64'(data3), 64'd0);
            check($sformatf("flush%0d_strobe", k), 64'(strb3), 64'd0);
        end

        // Random traffic against the model
        resetSeq();
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3)      FrameStrobe = '0;
            else if (r <= 7) FrameStrobe = 20'(1) << $urandom_range(0, 19);
            else if (r == 8) FrameStrobe = 20'($urandom);
            FrameData = $urandom;
            err_clr   = ($urandom_range(0, 7) == 0);
            step(1);
        end

        // Counter saturation: alternating one-hot bits give one event per cycle
        resetSeq();
        for (int n = 0; n < 65534; n++) begin
            setIn((n % 2 == 0) ? 20'h00001 : 20'h00002, 32'h0, 1'b0);
            step(0);
        end
        check("sat_preload", 64'(cnt2), 64'hFFFE);
        for (int n = 0; n < 3; n++) begin
            setIn((n % 2 == 0) ? 20'h00001 : 20'h00002, 32'h0, 1'b0);
            step(1);
            check($sformatf("sat%0d", n), 64'(cnt2), 64'hFFFF);
        end

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
